btn_event_decoder: RTL and testbench

BTN_EVENT_DECODER -- requirements
Module: btn_event_decoder

---
 rtl/btn_event_pkg.sv | 23 ++
 rtl/ms_tick_gen.sv | 30 +++
 rtl/btn_event_decoder.sv | 128 ++++++++++++
 tb/tb_btn_event_decoder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/btn_event_pkg.sv
// Shared definitions for the button event decoder: FSM encoding, default timing
// parameters and the millisecond counter width.
package btn_event_pkg;

   localparam int TICK_DIV_DEF  = 50000;
   localparam int LONG_MS_DEF   = 1000;
   localparam int DCLICK_MS_DEF = 300;
   localparam int MS_W          = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PRESS1 = 3'd1,
      ST_WAIT2  = 3'd2,
      ST_PRESS2 = 3'd3,
      ST_LONG   = 3'd4
   } state_e;

   // Saturating increment so a very long hold never wraps back below a threshold.
   function automatic logic [MS_W-1:0] sat_inc(input logic [MS_W-1:0] v);
      return (v == {MS_W{1'b1}}) ? v : v + MS_W'(1);
   endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running divider: counts 0..TICK_DIV-1 and flags the wrap cycle as a 1 ms tick.
module ms_tick_gen
   import btn_event_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEF
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   // High during the cycle whose edge performs the wrap to 0.
   assign tick = (cnt == LAST);

endmodule

// File: rtl/btn_event_decoder.sv
// Classifies a debounced active-low button into short press, long press and
// double click events, each reported as a single-cycle registered pulse.
module btn_event_decoder
   import btn_event_pkg::*;
#(
   parameter int TICK_DIV  = TICK_DIV_DEF,
   parameter int LONG_MS   = LONG_MS_DEF,
   parameter int DCLICK_MS = DCLICK_MS_DEF
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   db_in,
   output logic   short_p,
   output logic   long_p,
   output logic   dbl_p,
   output logic   held,
   output logic   busy,
   output state_e dbg_state
);

   localparam logic [MS_W-1:0] LONG_TH   = MS_W'(LONG_MS);
   localparam logic [MS_W-1:0] DCLICK_TH = MS_W'(DCLICK_MS);

   logic            tick;
   state_e          state;
   state_e          state_nx;
   logic [MS_W-1:0] ms_cnt;
   logic [MS_W-1:0] ms_inc;
   logic            long_hit;
   logic            dclick_hit;
   logic            short_nx;
   logic            long_nx;
   logic            dbl_nx;

   ms_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   // Thresholds count the tick arriving this cycle, so the Nth tick in a state is the hit.
   assign ms_inc     = sat_inc(ms_cnt);
   assign long_hit   = tick && (ms_inc >= LONG_TH);
   assign dclick_hit = tick && (ms_inc >= DCLICK_TH);

   always_comb begin
      state_nx = state;
      short_nx = 1'b0;
      long_nx  = 1'b0;
      dbl_nx   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!db_in) state_nx = ST_PRESS1;
         end
         ST_PRESS1: begin
            if (db_in) begin
               state_nx = ST_WAIT2;
            end else if (long_hit) begin
               state_nx = ST_LONG;
               long_nx  = 1'b1;
            end
         end
         ST_WAIT2: begin
            if (!db_in) begin
               state_nx = ST_PRESS2;
            end else if (dclick_hit) begin
               state_nx = ST_IDLE;
               short_nx = 1'b1;
            end
         end
         ST_PRESS2: begin
            if (db_in) begin
               state_nx = ST_IDLE;
               dbl_nx   = 1'b1;
            end else if (long_hit) begin
               state_nx = ST_LONG;
               long_nx  = 1'b1;
            end
         end
         ST_LONG: begin
            if (db_in) state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Elapsed time restarts on every state change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ms_cnt <= '0;
      end else if (state_nx != state) begin
         ms_cnt <= '0;
      end else if (tick) begin
         ms_cnt <= ms_inc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         short_p <= 1'b0;
         long_p  <= 1'b0;
         dbl_p   <= 1'b0;
         held    <= 1'b0;
         busy    <= 1'b0;
      end else begin
         short_p <= short_nx;
         long_p  <= long_nx;
         dbl_p   <= dbl_nx;
         held    <= (state_nx == ST_LONG);
         busy    <= (state_nx != ST_IDLE);
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_btn_event_decoder.sv
// Directed bench for btn_event_decoder with TICK_DIV=10, LONG_MS=20, DCLICK_MS=8.
module tb_btn_event_decoder;
   import btn_event_pkg::*;

   logic   clk   = 1'b0;
   logic   rst_n = 1'b0;
   logic   db_in = 1'b1;
   logic   short_p, long_p, dbl_p, held, busy;
   state_e dbg_state;

   int vectors     = 0;
   int miscompares = 0;

   // Edge count since reset release; ticks are sampled at edges 10, 20, 30, ...
   int cyc = 0;
   int n_short = 0, n_long = 0, n_dbl = 0, n_multi = 0;
   int last_short = -1, last_long = -1, last_dbl = -1;
   int b_short, b_long, b_dbl, b_multi;

   always #5 clk = ~clk;

   btn_event_decoder #(
      .TICK_DIV  (10),
      .LONG_MS   (20),
      .DCLICK_MS (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .db_in     (db_in),
      .short_p   (short_p),
      .long_p    (long_p),
      .dbl_p     (dbl_p),
      .held      (held),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (short_p === 1'b1) begin n_short++; last_short = cyc; end
         if (long_p  === 1'b1) begin n_long++;  last_long  = cyc; end
         if (dbl_p   === 1'b1) begin n_dbl++;   last_dbl   = cyc; end
         if ((int'(short_p) + int'(long_p) + int'(dbl_p)) > 1) n_multi++;
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic at(input int e);
      while (cyc < e) @(negedge clk);
   endtask

   // Reset with db_in already at lvl, release at a falling edge so cyc starts at 0.
   task automatic start(input logic lvl);
      @(negedge clk);
      rst_n = 1'b0;
      db_in = lvl;
      repeat (2) @(negedge clk);
      b_short = n_short;
      b_long  = n_long;
      b_dbl   = n_dbl;
      b_multi = n_multi;
      rst_n = 1'b1;
   endtask

   task automatic chk_counts(input string tag, input int es, input int el, input int ed);
      chk({tag, "_short_n"}, n_short - b_short, es);
      chk({tag, "_long_n"},  n_long  - b_long,  el);
      chk({tag, "_dbl_n"},   n_dbl   - b_dbl,   ed);
      chk({tag, "_multi"},   n_multi - b_multi, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      rst_n = 1'b0;
      db_in = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_short", int'(short_p), 0);
      chk("rst_long",  int'(long_p),  0);
      chk("rst_dbl",   int'(dbl_p),   0);
      chk("rst_held",  int'(held),    0);
      chk("rst_busy",  int'(busy),    0);
      chk("rst_state", int'(dbg_state), int'(ST_IDLE));

      // Short press: 5 ticks down, release, short_p at the 8th WAIT2 tick
      start(1'b0);
      at(1);   chk("a_busy_press", int'(busy), 1);
      at(50);  db_in = 1'b1;
      at(51);  chk("a_state_wait2", int'(dbg_state), int'(ST_WAIT2));
      at(150);
      chk_counts("a", 1, 0, 0);
      chk("a_short_cyc", last_short, 130);
      chk("a_busy_end", int'(busy), 0);

      // Double click: 3 ticks down, 3 up, 3 down, release
      start(1'b0);
      at(30);  db_in = 1'b1;
      at(60);  db_in = 1'b0;
      at(90);  db_in = 1'b1;
      at(200);
      chk_counts("b", 0, 0, 1);
      chk("b_dbl_cyc", last_dbl, 91);
      chk("b_busy_end", int'(busy), 0);

      // Long hold: long_p on the 20th tick, held until release
      start(1'b0);
      at(199); chk("c_held_pre", int'(held), 0);
      at(200); chk("c_held_on", int'(held), 1);
      at(250); chk("c_held_still", int'(held), 1);
      db_in = 1'b1;
      at(251); chk("c_held_off", int'(held), 0);
               chk("c_busy_off", int'(busy), 0);
      at(400);
      chk_counts("c", 0, 1, 0);
      chk("c_long_cyc", last_long, 200);

      // Release coincides with the 20th tick: release wins
      start(1'b0);
      at(199); db_in = 1'b1;
      at(200); chk("d_state_wait2", int'(dbg_state), int'(ST_WAIT2));
               chk("d_held", int'(held), 0);
      at(300);
      chk_counts("d", 1, 0, 0);
      chk("d_short_cyc", last_short, 280);

      // Second press coincides with the 8th WAIT2 tick: press wins
      start(1'b0);
      at(30);  db_in = 1'b1;
      at(109); db_in = 1'b0;
      at(110); chk("e_state_press2", int'(dbg_state), int'(ST_PRESS2));
      at(130); db_in = 1'b1;
      at(250);
      chk_counts("e", 0, 0, 1);
      chk("e_dbl_cyc", last_dbl, 131);

      // Second release coincides with the 20th PRESS2 tick: dbl_p, no long_p
      start(1'b0);
      at(30);  db_in = 1'b1;
      at(60);  db_in = 1'b0;
      at(259); db_in = 1'b1;
      at(400);
      chk_counts("f", 0, 0, 1);
      chk("f_dbl_cyc", last_dbl, 260);

      // Second press held to LONG: long_p only, silent release
      start(1'b0);
      at(30);  db_in = 1'b1;
      at(60);  db_in = 1'b0;
      at(300); chk("g_held", int'(held), 1);
      db_in = 1'b1;
      at(400);
      chk_counts("g", 0, 1, 0);
      chk("g_long_cyc", last_long, 260);
      chk("g_busy_end", int'(busy), 0);

      // Reset during PRESS1, button released while in reset: no event ever
      start(1'b0);
      at(45);
      rst_n = 1'b0;
      #1;
      chk("h_async_busy", int'(busy), 0);
      chk("h_async_state", int'(dbg_state), int'(ST_IDLE));
      @(negedge clk);
      db_in = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      at(300);
      chk_counts("h", 0, 0, 0);
      chk("h_busy_end", int'(busy), 0);

      // Button down across reset release starts a new press; async clear of held
      start(1'b0);
      chk("i_busy_rel", int'(busy), 0);
      at(1);   chk("i_busy_press", int'(busy), 1);
      at(210); chk("i_held", int'(held), 1);
      rst_n = 1'b0;
      #1;
      chk("i_async_held", int'(held), 0);
      chk("i_async_busy", int'(busy), 0);
      @(negedge clk);
      db_in = 1'b1;
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
